// File: rtl/jump_game_sequencer.sv
// Jump game sequencer: wall-step and jump-frame timebases, game state machine,
// LFSR wall scheduling, jump arbitration, collision judgement and score/highscore.
module jump_game_sequencer #(
  parameter int STEP_BASE  = 4000000,
  parameter int STEP_DEC   = 250000,
  parameter int STEP_MIN   = 2750000,
  parameter int FRAME_DIV  = 5000000,
  parameter int LEVEL_WINS = 5,
  parameter int TALL_STEP  = 32
) (
  input  logic       CLOCK_50,
  input  logic       RESET_N,
  input  logic       toggle,
  input  logic       new_game,
  input  logic       key_s_n,
  input  logic       key_l_n,
  output logic [1:0] game_state,
  output logic [3:0] wall_pos,
  output logic       wall_tall,
  output logic [1:0] jump_sel,
  output logic [3:0] jump_frame,
  output logic       clear_low,
  output logic       clear_high,
  output logic [7:0] score,
  output logic [7:0] highscore,
  output logic       new_high
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_RUN  = 2'b01,
    ST_EVAL = 2'b10,
    ST_LOST = 2'b11
  } state_t;

  localparam logic [1:0]  JUMP_NONE  = 2'b00;
  localparam logic [1:0]  JUMP_SMALL = 2'b01;
  localparam logic [1:0]  JUMP_LARGE = 2'b10;
  localparam logic [3:0]  SMALL_LAST = 4'd6;
  localparam logic [3:0]  LARGE_LAST = 4'd9;
  localparam logic [22:0] FRAME_LAST = 23'(FRAME_DIV - 1);

  function automatic logic [7:0] sat_inc8(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

  function automatic logic [2:0] level_of(input logic [7:0] s);
    int q;
    q = int'(s) / LEVEL_WINS;
    return (q > 6) ? 3'd6 : q[2:0];
  endfunction

  function automatic logic [21:0] step_last(input logic [2:0] lv);
    logic signed [31:0] p;
    p = STEP_BASE - int'(lv) * STEP_DEC;
    if (p < STEP_MIN) p = STEP_MIN;
    return 22'(p - 1);
  endfunction

  function automatic logic [7:0] lfsr_next(input logic [7:0] v);
    return {v[6:0], v[7] ^ v[5] ^ v[4] ^ v[3]};
  endfunction

  state_t      state;
  logic [21:0] step_cnt;
  logic [22:0] frame_cnt;
  logic [2:0]  level;
  logic [7:0]  lfsr;
  logic        ks_meta, ks_sync, kl_meta, kl_sync;
  logic        arm_s, arm_l;

  logic        key_s, key_l, active, step_tc, frame_tc, jump_end, cleared;
  logic [2:0]  lvl_now;
  logic [3:0]  jump_last;
  logic [7:0]  score_inc;

  assign key_s      = ~ks_sync;
  assign key_l      = ~kl_sync;
  assign active     = (state == ST_RUN) || (state == ST_EVAL);
  assign lvl_now    = level_of(score);
  assign step_tc    = (step_cnt == step_last(level));
  assign frame_tc   = (frame_cnt == FRAME_LAST);
  assign jump_last  = (jump_sel == JUMP_SMALL) ? SMALL_LAST : LARGE_LAST;
  assign jump_end   = (jump_sel != JUMP_NONE) && frame_tc && (jump_frame == jump_last);
  assign cleared    = wall_tall ? clear_high : clear_low;
  assign score_inc  = sat_inc8(score);
  assign game_state = state;

  always_comb begin
    clear_low  = 1'b0;
    clear_high = 1'b0;
    if (state != ST_LOST) begin
      clear_low  = ((jump_sel == JUMP_SMALL) && (jump_frame >= 4'd1) && (jump_frame <= 4'd4)) ||
                   ((jump_sel == JUMP_LARGE) && (jump_frame >= 4'd1) && (jump_frame <= 4'd5));
      clear_high = (jump_sel == JUMP_LARGE) && (jump_frame >= 4'd2) && (jump_frame <= 4'd4);
    end
  end

  // Key synchronisers keep sampling even while the game is frozen.
  always_ff @(posedge CLOCK_50 or negedge RESET_N) begin
    if (!RESET_N) begin
      ks_meta <= 1'b1;
      ks_sync <= 1'b1;
      kl_meta <= 1'b1;
      kl_sync <= 1'b1;
    end else begin
      ks_meta <= key_s_n;
      ks_sync <= ks_meta;
      kl_meta <= key_l_n;
      kl_sync <= kl_meta;
    end
  end

  always_ff @(posedge CLOCK_50 or negedge RESET_N) begin
    if (!RESET_N) begin
      state      <= ST_IDLE;
      wall_pos   <= '0;
      wall_tall  <= 1'b0;
      jump_sel   <= JUMP_NONE;
      jump_frame <= '0;
      score      <= '0;
      highscore  <= '0;
      new_high   <= 1'b0;
      step_cnt   <= '0;
      frame_cnt  <= '0;
      level      <= '0;
      lfsr       <= 8'hA5;
      arm_s      <= 1'b1;
      arm_l      <= 1'b1;
    end else if (toggle) begin
      new_high <= 1'b0;
      if (!key_s) arm_s <= 1'b1;
      if (!key_l) arm_l <= 1'b1;
      // A fresh game also restarts at level 0 so its first walls use the base period.
      if (new_game) begin
        state      <= ST_RUN;
        wall_pos   <= '0;
        step_cnt   <= '0;
        frame_cnt  <= '0;
        jump_sel   <= JUMP_NONE;
        jump_frame <= '0;
        score      <= '0;
        wall_tall  <= 1'b0;
        level      <= '0;
      end else if (active) begin
        if (step_tc) begin
          step_cnt <= '0;
          wall_pos <= wall_pos + 4'd1;
          if (wall_pos == 4'd15) begin
            wall_tall <= (int'(lfsr) < (int'(lvl_now) * TALL_STEP));
            lfsr      <= lfsr_next(lfsr);
            level     <= lvl_now;
          end
        end else begin
          step_cnt <= step_cnt + 22'd1;
        end

        if (state == ST_EVAL) begin
          if (cleared) begin
            score <= score_inc;
            state <= ST_RUN;
            if (score_inc > highscore) begin
              highscore <= score_inc;
              new_high  <= 1'b1;
            end
          end else begin
            state <= ST_LOST;
          end
        end else if (step_tc && (wall_pos == 4'd14)) begin
          state <= ST_EVAL;
        end

        // Jump frames; the key that finished a jump stays dis-armed until released.
        if (jump_sel != JUMP_NONE) begin
          if (frame_tc) begin
            frame_cnt  <= '0;
            jump_frame <= jump_frame + 4'd1;
          end else begin
            frame_cnt <= frame_cnt + 23'd1;
          end
          if (jump_end) begin
            jump_sel   <= JUMP_NONE;
            jump_frame <= '0;
            if (jump_sel == JUMP_SMALL) arm_s <= 1'b0;
            else                        arm_l <= 1'b0;
          end
        end else if (key_s && arm_s) begin
          jump_sel   <= JUMP_SMALL;
          jump_frame <= '0;
          frame_cnt  <= '0;
        end else if (key_l && arm_l) begin
          jump_sel   <= JUMP_LARGE;
          jump_frame <= '0;
          frame_cnt  <= '0;
        end
      end
    end
  end

endmodule

// File: tb/tb_jump_game_sequencer.sv
// Bench for jump_game_sequencer: directed scenarios plus a randomized player, every
// clock scoreboarded against a timeline-based reference model of the game rules.
module tb_jump_game_sequencer;

  localparam int STEP_BASE  = 8;
  localparam int STEP_DEC   = 2;
  localparam int STEP_MIN   = 4;
  localparam int FRAME_DIV  = 3;
  localparam int LEVEL_WINS = 1;
  localparam int TALL_STEP  = 32;

  logic       CLOCK_50 = 1'b0;
  logic       RESET_N  = 1'b0;
  logic       toggle   = 1'b0;
  logic       new_game = 1'b0;
  logic       key_s_n  = 1'b1;
  logic       key_l_n  = 1'b1;
  logic [1:0] game_state;
  logic [3:0] wall_pos;
  logic       wall_tall;
  logic [1:0] jump_sel;
  logic [3:0] jump_frame;
  logic       clear_low;
  logic       clear_high;
  logic [7:0] score;
  logic [7:0] highscore;
  logic       new_high;

  jump_game_sequencer #(
    .STEP_BASE(STEP_BASE), .STEP_DEC(STEP_DEC), .STEP_MIN(STEP_MIN),
    .FRAME_DIV(FRAME_DIV), .LEVEL_WINS(LEVEL_WINS), .TALL_STEP(TALL_STEP)
  ) dut (
    .CLOCK_50(CLOCK_50), .RESET_N(RESET_N), .toggle(toggle), .new_game(new_game),
    .key_s_n(key_s_n), .key_l_n(key_l_n), .game_state(game_state), .wall_pos(wall_pos),
    .wall_tall(wall_tall), .jump_sel(jump_sel), .jump_frame(jump_frame),
    .clear_low(clear_low), .clear_high(clear_high), .score(score),
    .highscore(highscore), .new_high(new_high)
  );

  always #5 CLOCK_50 = ~CLOCK_50;

  typedef struct packed {
    logic [1:0] st;
    logic [3:0] pos;
    logic       tall;
    logic [1:0] sel;
    logic [3:0] frame;
    logic       cl;
    logic       ch;
    logic [7:0] sc;
    logic [7:0] hs;
    logic       nh;
  } snap_t;

  snap_t exp_q[$];
  int    n_tests = 0;
  int    n_fail  = 0;
  int    nh_cnt  = 0;

  // Reference model: game state as a timeline (elapsed clocks since step / since jump grant).
  int m_state, m_pos, m_step, m_level, m_tall, m_lfsr, m_score, m_hs, m_nh;
  int m_kind, m_jt, m_arm_s, m_arm_l;
  int h_s0, h_s1, h_l0, h_l1;

  function automatic int m_clr_low();
    int f;
    f = m_jt / FRAME_DIV;
    if (m_state == 3) return 0;
    if (m_kind == 1) return int'(f >= 1 && f <= 4);
    if (m_kind == 2) return int'(f >= 1 && f <= 5);
    return 0;
  endfunction

  function automatic int m_clr_high();
    int f;
    f = m_jt / FRAME_DIV;
    if (m_state == 3) return 0;
    return int'(m_kind == 2 && f >= 2 && f <= 4);
  endfunction

  function automatic snap_t m_snap();
    snap_t s;
    s.st    = 2'(m_state);
    s.pos   = 4'(m_pos);
    s.tall  = 1'(m_tall);
    s.sel   = 2'(m_kind);
    s.frame = 4'(m_jt / FRAME_DIV);
    s.cl    = 1'(m_clr_low());
    s.ch    = 1'(m_clr_high());
    s.sc    = 8'(m_score);
    s.hs    = 8'(m_hs);
    s.nh    = 1'(m_nh);
    return s;
  endfunction

  function automatic snap_t dut_snap();
    return {game_state, wall_pos, wall_tall, jump_sel, jump_frame,
            clear_low, clear_high, score, highscore, new_high};
  endfunction

  function automatic string fmt(input snap_t s);
    return $sformatf("st=%0d pos=%0d tall=%0d sel=%0d fr=%0d cl=%0d ch=%0d sc=%0d hs=%0d nh=%0d",
                     s.st, s.pos, s.tall, s.sel, s.frame, s.cl, s.ch, s.sc, s.hs, s.nh);
  endfunction

  task automatic model_reset();
    m_state = 0; m_pos = 0; m_step = 0; m_level = 0; m_tall = 0; m_lfsr = 165;
    m_score = 0; m_hs = 0; m_nh = 0; m_kind = 0; m_jt = 0; m_arm_s = 1; m_arm_l = 1;
    h_s0 = 0; h_s1 = 0; h_l0 = 0; h_l1 = 0;
  endtask

  task automatic model_step();
    int ks, kl, lvl_now, per, cl, ch, cleared, nscore, fb;
    ks = h_s1; kl = h_l1;
    h_s1 = h_s0; h_l1 = h_l0;
    h_s0 = int'(!key_s_n); h_l0 = int'(!key_l_n);
    if (!toggle) return;
    cl = m_clr_low();
    ch = m_clr_high();
    m_nh = 0;
    if (ks == 0) m_arm_s = 1;
    if (kl == 0) m_arm_l = 1;
    if (new_game) begin
      m_state = 1; m_pos = 0; m_step = 0; m_kind = 0; m_jt = 0;
      m_score = 0; m_tall = 0; m_level = 0;
      return;
    end
    if (m_state != 1 && m_state != 2) return;
    lvl_now = m_score / LEVEL_WINS;
    if (lvl_now > 6) lvl_now = 6;
    per = STEP_BASE - m_level * STEP_DEC;
    if (per < STEP_MIN) per = STEP_MIN;
    cleared = (m_tall != 0) ? ch : cl;
    if (m_state == 2) begin
      if (cleared != 0) begin
        nscore = (m_score < 255) ? m_score + 1 : 255;
        if (nscore > m_hs) begin m_hs = nscore; m_nh = 1; end
        m_score = nscore;
        m_state = 1;
      end else begin
        m_state = 3;
      end
    end
    m_step++;
    if (m_step == per) begin
      m_step = 0;
      if (m_pos == 15) begin
        m_tall  = int'(m_lfsr < lvl_now * TALL_STEP);
        fb      = ((m_lfsr >> 7) ^ (m_lfsr >> 5) ^ (m_lfsr >> 4) ^ (m_lfsr >> 3)) & 1;
        m_lfsr  = ((m_lfsr << 1) | fb) & 255;
        m_level = lvl_now;
        m_pos   = 0;
      end else begin
        m_pos++;
        if (m_pos == 15) m_state = 2;
      end
    end
    if (m_kind != 0) begin
      m_jt++;
      if (m_jt == (((m_kind == 1) ? 6 : 9) + 1) * FRAME_DIV) begin
        if (m_kind == 1) m_arm_s = 0; else m_arm_l = 0;
        m_kind = 0;
        m_jt = 0;
      end
    end else if (ks != 0 && m_arm_s != 0) begin
      m_kind = 1; m_jt = 0;
    end else if (kl != 0 && m_arm_l != 0) begin
      m_kind = 2; m_jt = 0;
    end
  endtask

  always @(posedge CLOCK_50) begin
    if (!RESET_N) model_reset();
    else          model_step();
    exp_q.push_back(m_snap());
  end

  always @(negedge CLOCK_50) begin
    snap_t e, a;
    if (exp_q.size() != 0) begin
      e = exp_q.pop_front();
      a = dut_snap();
      n_tests++;
      if (a !== e) begin
        n_fail++;
        $display("FAIL scoreboard t=%0t got %s | expected %s", $time, fmt(a), fmt(e));
      end
    end
  end

  task automatic check(input string name, input int act, input int exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge CLOCK_50);
      #1;
      if (new_high) nh_cnt++;
    end
  endtask

  task automatic pulse_new_game();
    new_game = 1'b1;
    tick(1);
    new_game = 1'b0;
  endtask

  initial begin
    int cycles, frz, hold, target;
    frz = 0;
    hold = 0;

    tick(3);
    check("reset_state", int'(dut_snap()), 0);
    @(negedge CLOCK_50);
    #1;
    RESET_N = 1'b1;
    toggle  = 1'b1;
    tick(2);

    // No keys: the first wall is missed.
    pulse_new_game();
    cycles = 0;
    while (cycles < 300 && game_state != 2'b11) begin
      tick(1);
      cycles++;
    end
    check("lost_latency", cycles, 15 * STEP_BASE + 1);
    check("lost_pos", int'(wall_pos), 15);
    check("lost_score", int'(score), 0);
    tick(10);
    check("lost_frozen_pos", int'(wall_pos), 15);

    // Small jump timed so frame 2 covers the evaluation clock.
    nh_cnt = 0;
    pulse_new_game();
    tick(110);
    key_s_n = 1'b0;
    tick(5);
    key_s_n = 1'b1;
    tick(6);
    check("win_score", int'(score), 1);
    check("win_high", int'(highscore), 1);
    tick(7);
    check("wrap_pos0", int'(wall_pos), 0);
    tick(5);
    check("period6_hold", int'(wall_pos), 0);
    tick(1);
    check("period6_step", int'(wall_pos), 1);
    check("new_high_once", nh_cnt, 1);

    // Both keys together, then held past the end of the jump.
    pulse_new_game();
    key_s_n = 1'b0;
    key_l_n = 1'b0;
    tick(3);
    check("both_keys_small", int'(jump_sel), 1);
    key_l_n = 1'b1;
    tick(25);
    check("held_no_regrant", int'(jump_sel), 0);
    key_s_n = 1'b1;
    tick(3);
    key_s_n = 1'b0;
    tick(3);
    check("regrant", int'(jump_sel), 1);
    key_s_n = 1'b1;

    // Freeze mid-jump, then resume.
    tick(4);
    toggle = 1'b0;
    tick(20);
    toggle = 1'b1;
    tick(3);

    // Asynchronous reset mid-jump.
    key_s_n = 1'b0;
    tick(6);
    @(negedge CLOCK_50);
    #1;
    RESET_N = 1'b0;
    key_s_n = 1'b1;
    #1;
    check("async_reset", int'(dut_snap()), 0);
    tick(2);
    @(negedge CLOCK_50);
    #1;
    RESET_N = 1'b1;
    tick(2);

    // Randomized player: mostly well-timed large jumps, some small jumps and noise.
    for (int c = 0; c < 12000; c++) begin
      if (frz > 0) begin
        toggle = 1'b0;
        frz--;
      end else begin
        toggle = 1'b1;
        if ($urandom_range(0, 399) == 0) frz = $urandom_range(5, 25);
      end
      new_game = 1'b0;
      if ((game_state == 2'b11 || game_state == 2'b00) && $urandom_range(0, 19) == 0)
        new_game = 1'b1;
      else if ($urandom_range(0, 2999) == 0)
        new_game = 1'b1;
      target = (score < 8'd2) ? 13 : 12;
      if (hold > 0) begin
        hold--;
        if (hold == 0) begin
          key_s_n = 1'b1;
          key_l_n = 1'b1;
        end
      end else if (jump_sel == 2'b00 && game_state == 2'b01 && int'(wall_pos) == target) begin
        if ($urandom_range(0, 3) == 0) key_s_n = 1'b0;
        else                           key_l_n = 1'b0;
        if ($urandom_range(0, 7) == 0) begin
          key_s_n = 1'b0;
          key_l_n = 1'b0;
        end
        hold = $urandom_range(1, 12);
      end else if (wall_pos < 4'd8 && $urandom_range(0, 99) == 0) begin
        key_s_n = 1'($urandom_range(0, 1));
        key_l_n = 1'($urandom_range(0, 1));
        hold = $urandom_range(1, 8);
      end
      tick(1);
    end

    new_game = 1'b0;
    toggle = 1'b1;
    key_s_n = 1'b1;
    key_l_n = 1'b1;
    tick(3);
    @(negedge CLOCK_50);
    #1;
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
